firebird7_in_gate2_sol_activity_monitor: RTL and testbench
==========================================================

// Module: firebird7_in_gate2_sol_activity_monitor
// PURPOSE
//  Scan-out-line activity monitor sitting directly upstream of the
//  gate2 extest/EDT scan BI status TDR. Samples one scan-out line and
//  produces sol_out, a sticky toggle flag and a saturating activity count.
//  Counting runs over a programmable window of TCK cycles and is controlled
//  by start/clear pulses from the gate2 control TDR.
//  The TDR captures the status outputs.
// PARAMETERS
//  CNT_W  15  activity counter width; must match TDR sol_cnt_status width
//  WIN_W  16  window length register width
// PORTS
//  ijtag_tck       in   1      single clock for the whole block
//  ijtag_reset     in   1      synchronous, active-high reset
//  scan_out_line   in   1      monitored scan-out line
//  mon_start       in   1      1-cycle pulse; arm and start a window
//  mon_clr         in   1      1-cycle pulse; abort, zero status
//  mon_mode        in   1      0=count transitions, 1=count cycles line==1
//  win_len         in   WIN_W  window length in samples; 0=free-run
//  sol_out         out  1      registered line sample
//  sol_tog_status  out  1      sticky: >=1 transition seen in window
//  sol_cnt_status  out  CNT_W  saturating activity count
//  mon_busy        out  1      state is ARM or COUNT
//  mon_done        out  1      state is DONE
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, samp_q=last_q=0, win_rem=0.
//  - Sampling, every cycle, in every state:
//    - samp_q<=line (via sync if enabled); last_q<=samp_q.
//    - sol_out=samp_q, giving 1-cycle latency.
//  - FSM IDLE/ARM/COUNT/DONE:
//    - IDLE: mon_start -> ARM.
//    - ARM, 1 cycle: cnt<=0, tog<=0, win_rem<=win_len; -> COUNT.
//    - COUNT: each cycle evaluates one sample.
//      - event = mon_mode ? samp_q : (samp_q^last_q).
//      - If event, cnt<=cnt+1, saturating at all-ones.
//      - tog<=tog|(samp_q^last_q), in either mode.
//      - If win_len!=0: win_rem--; win_rem==1 this cycle -> DONE.
//        Exactly win_len samples are evaluated.
//      - If win_len==0: stay in COUNT until mon_clr or mon_start.
//    - DONE: cnt/tog frozen. mon_start -> ARM (restart); mon_clr -> IDLE.
//  - mon_start in COUNT -> ARM (restart window).
//  - mon_clr in any state -> IDLE, cnt=0, tog=0. Wins over a same-cycle
//    mon_start.
//  - win_len is sampled only in ARM; changes during COUNT are ignored.
//  - Saturation: cnt holds at 2^CNT_W-1. No wrap, no overflow flag.
//  - Status outputs are plain registers, stable except on counting
//    cycles; no handshake with the TDR capture.
//  - Reset asserted mid-window: next edge forces IDLE and clears everything.
// CONFIGURATION
//  SOL_MON_SYNC_EN defined:
//    - 2-flop synchronizer inserted before samp_q.
//    - sol_out latency from line = 3 cycles; sync flops reset to 0.
//  Not defined:
//    - line registered directly into samp_q; latency 1 cycle.
//  Counting semantics are identical in both builds; only latency differs.
// TESTING
//  T1 reset: hold ijtag_reset 3 cycles, line=1 -> all outputs 0, IDLE.
//  T2 toggle: mode=0, win_len=8, line alternating every cycle from start
//     -> after ARM+8 cycles mon_done=1, cnt=8, tog=1.
//  T3 ones: mode=1, win_len=20, line held 1 -> cnt=20, tog=0, mon_done=1.
//  T4 saturation: win_len=0, line toggling, run 40000 cycles
//     -> cnt=0x7FFF held, mon_busy=1; then mon_clr -> cnt=0, IDLE.
//  T5 collision: in COUNT (cnt=5), mon_clr and mon_start same cycle
//     -> IDLE next cycle, cnt=0, tog=0, busy=0.
//  T6 macro: single 0->1 line step; sol_out rises 1 cycle later without
//     SOL_MON_SYNC_EN, 3 cycles later with it.

Source files
------------

// File: rtl/firebird7_in_gate2_sol_activity_monitor_if.sv
// Signal bundle between the gate2 control/status TDR side and the scan-out-line activity monitor.
// The TDR side uses the master modport and the monitor uses the slave modport.
interface firebird7_in_gate2_sol_activity_monitor_if #(
  parameter int CNT_W = 15,
  parameter int WIN_W = 16
);
  logic             scan_out_line;
  logic             mon_start;
  logic             mon_clr;
  logic             mon_mode;
  logic [WIN_W-1:0] win_len;
  logic             sol_out;
  logic             sol_tog_status;
  logic [CNT_W-1:0] sol_cnt_status;
  logic             mon_busy;
  logic             mon_done;

  modport master (
    output scan_out_line, mon_start, mon_clr, mon_mode, win_len,
    input  sol_out, sol_tog_status, sol_cnt_status, mon_busy, mon_done
  );

  modport slave (
    input  scan_out_line, mon_start, mon_clr, mon_mode, win_len,
    output sol_out, sol_tog_status, sol_cnt_status, mon_busy, mon_done
  );
endinterface

// File: rtl/firebird7_in_gate2_sol_activity_monitor.sv
// Scan-out-line activity monitor: registered line sample, sticky toggle flag and saturating count over a TCK window.
// Optional macro SOL_MON_SYNC_EN inserts a 2-flop synchronizer ahead of the sample register.
module firebird7_in_gate2_sol_activity_monitor #(
  parameter int CNT_W = 15,
  parameter int WIN_W = 16
) (
  input  logic ijtag_tck,
  input  logic ijtag_reset,
  firebird7_in_gate2_sol_activity_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q;
  logic             samp_q;
  logic             last_q;
  logic             line_s;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tog_q;
  logic             tog_d;
  logic [WIN_W-1:0] win_rem_q;
  logic             busy_q;
  logic             done_q;
  logic             evt;

`ifdef SOL_MON_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= mon.scan_out_line;
      sync2_q <= sync1_q;
    end
  end

  assign line_s = sync2_q;
`else
  assign line_s = mon.scan_out_line;
`endif

  // Sample pipeline runs in every state; last_q holds the previous sample for edge detection.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      samp_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so last_q captures the old samp_q, not the value written this edge.
      samp_q <= line_s;
      last_q <= samp_q;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    evt   = mon.mon_mode ? samp_q : (samp_q ^ last_q);
    cnt_d = cnt_q;
    tog_d = tog_q | (samp_q ^ last_q);
    if (evt && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // win_rem_q==0 while counting means free-run; a finite window leaves COUNT when it reaches 1.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset || mon.mon_clr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tog_q     <= 1'b0;
      win_rem_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mon.mon_start) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
          end
        end
        ARM: begin
          cnt_q     <= '0;
          tog_q     <= 1'b0;
          win_rem_q <= mon.win_len;
          state_q   <= COUNT;
        end
        COUNT: begin
          if (mon.mon_start) begin
            state_q <= ARM;
          end else begin
            cnt_q <= cnt_d;
            tog_q <= tog_d;
            if (win_rem_q != '0) begin
              win_rem_q <= win_rem_q - WIN_W'(1);
              if (win_rem_q == WIN_W'(1)) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (mon.mon_start) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mon.sol_out        = samp_q;
  assign mon.sol_tog_status = tog_q;
  assign mon.sol_cnt_status = cnt_q;
  assign mon.mon_busy       = busy_q;
  assign mon.mon_done       = done_q;

endmodule

// File: tb/tb_firebird7_in_gate2_sol_activity_monitor.sv
// Self-checking bench for the scan-out-line activity monitor: directed scenarios plus randomized traffic,
// every cycle compared against a window-level behavioural model.
module tb_firebird7_in_gate2_sol_activity_monitor;

  localparam int CNT_W = 15;
  localparam int WIN_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef SOL_MON_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  localparam int P_IDLE  = 0;
  localparam int P_ARM   = 1;
  localparam int P_COUNT = 2;
  localparam int P_DONE  = 3;

  logic clk;
  logic rst;

  firebird7_in_gate2_sol_activity_monitor_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

  firebird7_in_gate2_sol_activity_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .ijtag_tck   (clk),
    .ijtag_reset (rst),
    .mon         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: line history queue for latency, unbounded event total clamped on output,
  // and a count of samples evaluated against the window length latched at arm time.
  bit hist[$];
  int m_phase = P_IDLE;
  int m_ev    = 0;
  int m_evald = 0;
  int m_win   = 0;
  bit m_tog   = 0;

  initial for (int i = 0; i <= LAT; i++) hist.push_back(1'b0);

  always @(posedge clk) begin : model
    bit s;
    bit l;
    if (rst) begin
      m_phase = P_IDLE;
      m_ev    = 0;
      m_tog   = 0;
      for (int i = 0; i <= LAT; i++) hist[i] = 1'b0;
    end else begin
      s = hist[LAT-1];
      l = hist[LAT];
      if (bus.mon_clr) begin
        m_phase = P_IDLE;
        m_ev    = 0;
        m_tog   = 0;
      end else begin
        case (m_phase)
          P_IDLE: if (bus.mon_start) m_phase = P_ARM;
          P_ARM: begin
            m_ev    = 0;
            m_tog   = 0;
            m_evald = 0;
            m_win   = int'(bus.win_len);
            m_phase = P_COUNT;
          end
          P_COUNT: begin
            if (bus.mon_start) m_phase = P_ARM;
            else begin
              if (bus.mon_mode ? s : (s ^ l)) m_ev++;
              m_tog = m_tog | (s ^ l);
              if (m_win != 0) begin
                m_evald++;
                if (m_evald == m_win) m_phase = P_DONE;
              end
            end
          end
          default: if (bus.mon_start) m_phase = P_ARM;
        endcase
      end
      hist.push_front(bus.scan_out_line);
      void'(hist.pop_back());
    end
  end

  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("sol_out",  bus.sol_out, hist[LAT-1]);
      check("sol_cnt",  bus.sol_cnt_status, (m_ev > CMAX) ? CMAX : m_ev);
      check("sol_tog",  bus.sol_tog_status, m_tog);
      check("mon_busy", bus.mon_busy, (m_phase == P_ARM) || (m_phase == P_COUNT));
      check("mon_done", bus.mon_done, m_phase == P_DONE);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.mon_start = 1'b1;
    tick();
    bus.mon_start = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.mon_clr = 1'b1;
    tick();
    bus.mon_clr = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int r;
    rst               = 1'b1;
    bus.scan_out_line = 1'b1;
    bus.mon_start     = 1'b0;
    bus.mon_clr       = 1'b0;
    bus.mon_mode      = 1'b0;
    bus.win_len       = '0;

    // T1: reset held with line high
    repeat (3) tick();
    check("t1_sol_out", bus.sol_out, 0);
    check("t1_tog",     bus.sol_tog_status, 0);
    check("t1_cnt",     bus.sol_cnt_status, 0);
    check("t1_busy",    bus.mon_busy, 0);
    check("t1_done",    bus.mon_done, 0);
    rst    = 1'b0;
    cmp_en = 1;

    // T2: transitions, 8-sample window, line alternating every cycle
    bus.mon_mode      = 1'b0;
    bus.win_len       = 16'd8;
    bus.scan_out_line = 1'b0;
    repeat (4) tick();
    bus.scan_out_line = 1'b1;
    pulse_start();
    n = 0;
    while (!bus.mon_done && n < 40) begin
      bus.scan_out_line = ~bus.scan_out_line;
      tick();
      n++;
    end
    check("t2_done", bus.mon_done, 1);
    check("t2_cnt",  bus.sol_cnt_status, 8);
    check("t2_tog",  bus.sol_tog_status, 1);
    pulse_clr();

    // T3: ones mode, 20-sample window, line held high
    bus.mon_mode      = 1'b1;
    bus.win_len       = 16'd20;
    bus.scan_out_line = 1'b1;
    repeat (5) tick();
    pulse_start();
    n = 0;
    while (!bus.mon_done && n < 60) begin
      tick();
      n++;
    end
    check("t3_done", bus.mon_done, 1);
    check("t3_cnt",  bus.sol_cnt_status, 20);
    check("t3_tog",  bus.sol_tog_status, 0);
    pulse_clr();

    // T4: free-run saturation
    bus.mon_mode = 1'b0;
    bus.win_len  = '0;
    pulse_start();
    for (int i = 0; i < 40000; i++) begin
      bus.scan_out_line = ~bus.scan_out_line;
      tick();
    end
    check("t4_cnt_sat", bus.sol_cnt_status, 32'h7FFF);
    check("t4_busy",    bus.mon_busy, 1);
    pulse_clr();
    check("t4_clr_cnt",  bus.sol_cnt_status, 0);
    check("t4_clr_busy", bus.mon_busy, 0);

    // T5: clear and start in the same cycle while counting
    bus.mon_mode      = 1'b1;
    bus.scan_out_line = 1'b1;
    repeat (4) tick();
    pulse_start();
    n = 0;
    while (bus.sol_cnt_status != 5 && n < 20) begin
      tick();
      n++;
    end
    check("t5_cnt_pre", bus.sol_cnt_status, 5);
    bus.mon_clr   = 1'b1;
    bus.mon_start = 1'b1;
    tick();
    bus.mon_clr   = 1'b0;
    bus.mon_start = 1'b0;
    check("t5_cnt",  bus.sol_cnt_status, 0);
    check("t5_tog",  bus.sol_tog_status, 0);
    check("t5_busy", bus.mon_busy, 0);
    tick();
    check("t5_still_idle", bus.mon_busy, 0);

    // T6: sample latency of a single 0->1 step
    bus.scan_out_line = 1'b0;
    repeat (6) tick();
    bus.scan_out_line = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.sol_out && n < 10);
    check("t6_latency", n, LAT);

    // Randomized traffic: pulses, collisions, mode/window changes, occasional reset
    for (int i = 0; i < 3000; i++) begin
      r                 = int'($urandom_range(99));
      bus.mon_start     = (r < 6) || (r == 10);
      bus.mon_clr       = (r >= 6 && r < 9) || (r == 10);
      rst               = ($urandom_range(299) == 0);
      if ($urandom_range(15) == 0) bus.mon_mode = 1'($urandom_range(1));
      if ($urandom_range(7) == 0)
        bus.win_len = ($urandom_range(3) == 0) ? '0 : WIN_W'($urandom_range(12, 1));
      bus.scan_out_line = 1'($urandom_range(1));
      tick();
    end
    rst           = 1'b0;
    bus.mon_start = 1'b0;
    bus.mon_clr   = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
